// File: rtl/bus_cycle_master.sv
// bus_cycle_master: initiator side of a multiplexed 8-bit AD bus using
// 8085-style T-states (T1, T2, TW..., T3, T4).
// A single-beat local request is captured in IDLE and then played out on the bus.
// A wait-state limit aborts the cycle with err if the responder never asserts ready.
module bus_cycle_master #(
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   output logic        req_rdy,
   input  logic        req_wr,
   input  logic        req_io,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic [7:0]  rdata,
   output logic        done,
   output logic        err,
   output logic        ale,
   output logic        io_m,
   output logic        rd_n,
   output logic        wr_n,
   output logic [7:0]  a_hi,
   output logic [7:0]  ad_out,
   output logic        ad_oe,
   input  logic [7:0]  ad_in,
   input  logic        ready
);

   // One-hot T-state encoding.
   typedef enum logic [5:0] {
      S_IDLE = 6'b000001,
      S_T1   = 6'b000010,
      S_T2   = 6'b000100,
      S_TW   = 6'b001000,
      S_T3   = 6'b010000,
      S_T4   = 6'b100000
   } state_t;

   // Counter value seen during the last allowed wait state.
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t      state;
   state_t      state_nxt;
   logic        cap_wr;
   logic        cap_io;
   logic [15:0] cap_addr;
   logic [7:0]  cap_wdata;
   logic [7:0]  wait_cnt;
   logic        timeout;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, regardless of the order the blocks are evaluated in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic. ready is only consulted in T2 and TW.
   // NOTE: state_nxt gets a default before the case so no path leaves it
   // unassigned; otherwise a latch would be inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (req) state_nxt = S_T1;
         S_T1:   state_nxt = S_T2;
         S_T2:   state_nxt = ready ? S_T3 : S_TW;
         S_TW: begin
            if (ready)                      state_nxt = S_T3;
            else if (wait_cnt == WAIT_LAST) state_nxt = S_T4;
         end
         S_T3:   state_nxt = S_T4;
         S_T4:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Request capture, wait counting, timeout flag and read-data register.
   // NOTE: every register here has an explicit reset value, including the
   // capture registers. A reset in the middle of a cycle therefore leaves
   // nothing stale behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_wr    <= 1'b0;
         cap_io    <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         wait_cnt  <= '0;
         timeout   <= 1'b0;
         rdata     <= '0;
      end else begin
         if (state == S_IDLE && req) begin
            cap_wr    <= req_wr;
            cap_io    <= req_io;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            wait_cnt  <= '0;
         end
         if (state == S_TW) begin
            wait_cnt <= wait_cnt + 8'd1;
            if (!ready && wait_cnt == WAIT_LAST) timeout <= 1'b1;
         end
         if (state == S_T3 && !cap_wr) rdata <= ad_in;
         if (state == S_T4) timeout <= 1'b0;
      end
   end

   // Bus outputs decoded from the state and captured fields only.
   // There is no combinational path from req* to the bus pins.
   always_comb begin
      req_rdy = 1'b0;
      ale     = 1'b0;
      io_m    = 1'b0;
      rd_n    = 1'b1;
      wr_n    = 1'b1;
      a_hi    = '0;
      ad_out  = '0;
      ad_oe   = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
      unique case (state)
         S_IDLE: req_rdy = 1'b1;
         S_T1: begin
            ale    = 1'b1;
            io_m   = cap_io;
            a_hi   = cap_addr[15:8];
            ad_oe  = 1'b1;
            ad_out = cap_addr[7:0];
         end
         S_T2, S_TW, S_T3: begin
            io_m   = cap_io;
            a_hi   = cap_addr[15:8];
            rd_n   = cap_wr;
            wr_n   = ~cap_wr;
            ad_oe  = cap_wr;
            ad_out = cap_wr ? cap_wdata : 8'h00;
         end
         S_T4: begin
            io_m = cap_io;
            a_hi = cap_addr[15:8];
            done = 1'b1;
            err  = timeout;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bus_cycle_master.sv
// Testbench for bus_cycle_master.
// A transaction-level model builds the expected pin trace from phase lengths:
// T1, then a strobe phase (T2 plus the waits, plus T3 unless the cycle timed out), T4 and one IDLE cycle.
module tb_bus_cycle_master;

   localparam int MAX_WAIT = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        req_rdy;
   logic        req_wr;
   logic        req_io;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic [7:0]  rdata;
   logic        done;
   logic        err;
   logic        ale;
   logic        io_m;
   logic        rd_n;
   logic        wr_n;
   logic [7:0]  a_hi;
   logic [7:0]  ad_out;
   logic        ad_oe;
   logic [7:0]  ad_in;
   logic        ready;

   int total = 0;
   int bad   = 0;
   logic [7:0] model_rdata;

   bus_cycle_master #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_rdy(req_rdy), .req_wr(req_wr),
      .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
      .rdata(rdata), .done(done), .err(err), .ale(ale), .io_m(io_m),
      .rd_n(rd_n), .wr_n(wr_n), .a_hi(a_hi), .ad_out(ad_out), .ad_oe(ad_oe),
      .ad_in(ad_in), .ready(ready)
   );

   always #5 clk = ~clk;

   // Runs one bus cycle from an IDLE cycle (at its falling edge). It checks
   // every cycle through the IDLE cycle that follows T4, and returns at that
   // cycle's falling edge. nwait is the number of wait states before ready=1.
   // stuck holds ready low until the timeout. t3_val is driven on ad_in during T3.
   task automatic do_txn(input bit wr, input bit io, input logic [15:0] addr,
                         input logic [7:0] wdata, input int nwait, input bit stuck,
                         input logic [7:0] t3_val, input string tag);
      int slen, ncyc, k;
      bit e_rdy, e_ale, e_io, e_rdn, e_wrn, e_done, e_err, e_oe;
      logic [7:0] e_ahi, e_ado;
      logic [31:0] exp_v, act_v;
      slen = stuck ? (1 + MAX_WAIT) : (2 + nwait);
      ncyc = slen + 3;
      req = 1'b1; req_wr = wr; req_io = io; req_addr = addr; req_wdata = wdata;
      ready = 1'($urandom); ad_in = 8'($urandom);
      @(posedge clk);
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         e_rdy = 0; e_ale = 0; e_io = io; e_ahi = addr[15:8];
         e_rdn = 1; e_wrn = 1; e_oe = 0; e_ado = 8'h00; e_done = 0; e_err = 0;
         if (c == 1) begin
            e_ale = 1; e_oe = 1; e_ado = addr[7:0];
         end else if (c <= 1 + slen) begin
            e_rdn = wr; e_wrn = !wr; e_oe = wr; e_ado = wr ? wdata : 8'h00;
         end else if (c == 2 + slen) begin
            e_done = 1; e_err = stuck;
         end else begin
            e_rdy = 1; e_io = 0; e_ahi = 8'h00;
         end
         exp_v = {e_rdy, e_ale, e_io, e_rdn, e_wrn, e_done, e_err, e_oe, e_ahi, e_ado, model_rdata};
         act_v = {req_rdy, ale, io_m, rd_n, wr_n, done, err, ad_oe, a_hi,
                  (e_oe ? ad_out : 8'h00), rdata};
         total++;
         if (act_v !== exp_v) begin
            bad++;
            $display("FAIL %s cycle %0d: got rdy/ale/io/rd_n/wr_n/done/err/oe/a_hi/ad/rdata=%h required %h",
                     tag, c, act_v, exp_v);
         end
         total++;
         if (rd_n === 1'b0 && wr_n === 1'b0) begin
            bad++;
            $display("FAIL %s cycle %0d strobe overlap: got rd_n=%b wr_n=%b required not both 0",
                     tag, c, rd_n, wr_n);
         end
         // Stimulus for the edge that ends this cycle.
         k = c - 2;
         if (c >= 2 && c <= 1 + slen && (stuck || k <= nwait))
            ready = !stuck && (k == nwait);
         else
            ready = 1'($urandom);
         ad_in = 8'($urandom);
         if (!stuck && c == 1 + slen) begin
            ad_in = t3_val;
            if (!wr) model_rdata = t3_val;
         end
         // While the cycle is busy, keep req high with unrelated fields.
         // The captured values must not change.
         if (c < ncyc) begin
            req = 1'b1; req_wr = 1'($urandom); req_io = 1'($urandom);
            req_addr = 16'($urandom); req_wdata = 8'($urandom);
         end else begin
            req = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] exp_v;
      rst = 1'b1; req = 1'b0; req_wr = 0; req_io = 0; req_addr = '0; req_wdata = '0;
      ad_in = '0; ready = 1'b0; model_rdata = 8'h00;
      exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      repeat (2) begin
         @(negedge clk);
         total++;
         if ({req_rdy, ale, io_m, rd_n, wr_n, done, err, ad_oe, a_hi, ad_out, rdata} !== exp_v) begin
            bad++;
            $display("FAIL reset: got %h required %h",
                     {req_rdy, ale, io_m, rd_n, wr_n, done, err, ad_oe, a_hi, ad_out, rdata}, exp_v);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_zero_wait_read();
      do_txn(1'b0, 1'b0, 16'h12A5, 8'h00, 0, 1'b0, 8'h3C, "zero_wait_read");
   endtask

   task automatic test_io_write_waits();
      do_txn(1'b1, 1'b1, 16'h0040, 8'h7E, 2, 1'b0, 8'h00, "io_write_2wait");
   endtask

   task automatic test_timeout();
      do_txn(1'b0, 1'b0, 16'h8001, 8'h00, 1, 1'b0, 8'hC3, "read_before_timeout");
      do_txn(1'b0, 1'b0, 16'h4321, 8'h00, 0, 1'b1, 8'h99, "timeout_read");
      do_txn(1'b1, 1'b0, 16'h5A5A, 8'hE1, 0, 1'b1, 8'h00, "timeout_write");
      do_txn(1'b0, 1'b1, 16'h00FF, 8'h00, MAX_WAIT, 1'b0, 8'h6D, "max_wait_ok");
   endtask

   task automatic test_reset_mid_cycle();
      req = 1'b1; req_wr = 1'b1; req_io = 1'b0; req_addr = 16'hBEEF; req_wdata = 8'h55;
      ready = 1'b0;
      @(posedge clk);
      @(negedge clk);        // T1
      req = 1'b0;
      @(negedge clk);        // T2
      @(negedge clk);        // TW 1
      total++;
      if (wr_n !== 1'b0 || ad_out !== 8'h55) begin
         bad++;
         $display("FAIL mid_tw_before_reset: got wr_n=%b ad_out=%h required 0 55", wr_n, ad_out);
      end
      @(negedge clk);        // TW 2
      rst = 1'b1;
      #1;
      total++;
      if ({wr_n, rd_n, ad_oe, a_hi, done, io_m} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset_mid_tw: got wr_n=%b rd_n=%b ad_oe=%b a_hi=%h done=%b io_m=%b required 1 1 0 00 0 0",
                  wr_n, rd_n, ad_oe, a_hi, done, io_m);
      end
      model_rdata = 8'h00;
      repeat (3) begin
         @(negedge clk);
         total++;
         if (done !== 1'b0 || req_rdy !== 1'b1 || rdata !== 8'h00) begin
            bad++;
            $display("FAIL reset_hold: got done=%b req_rdy=%b rdata=%h required 0 1 00", done, req_rdy, rdata);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      do_txn(1'b0, 1'b0, 16'hA0B1, 8'h00, 1, 1'b0, 8'h42, "read_after_reset");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++)
         do_txn(1'(i % 2), 1'($urandom), 16'($urandom), 8'($urandom), 0, 1'b0,
                8'($urandom), "back_to_back");
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++)
         do_txn(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom),
                $urandom_range(0, MAX_WAIT), ($urandom_range(0, 5) == 0),
                8'($urandom), "random");
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_zero_wait_read();
      test_io_write_waits();
      test_timeout();
      test_reset_mid_cycle();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_cycle_master.md
Name: bus_cycle_master

Overview:
- Initiator end of the multiplexed 8-bit address/data bus (8085-style T-state timing).
- Takes single-beat read/write requests from the local side and generates ALE, IO/M, RD_n, WR_n and the multiplexed AD bus, honouring READY wait states.
- Pairs with the existing bus-cycle responder that decodes ALE/io/RD/WR into rd/wr strobes.
- Adds a wait-state timeout so a dead responder cannot hang the bus.

Parameters:
- MAX_WAIT, 8, maximum consecutive wait states (TW cycles) before the cycle is aborted with err; range 1..255.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  local request valid; accepted only when req_rdy=1.
- req_rdy  output  1  high only in IDLE; req & req_rdy = acceptance.
- req_wr  input  1  1=write, 0=read; captured at acceptance.
- req_io  input  1  1=I/O cycle, 0=memory cycle; captured at acceptance.
- req_addr  input  16  cycle address; captured at acceptance.
- req_wdata  input  8  write data; captured at acceptance.
- rdata  output  8  read data; updated only on a successful read, held otherwise.
- done  output  1  one-cycle pulse in T4 of every cycle.
- err  output  1  valid with done; 1 = timed out waiting for READY.
- ale  output  1  address latch enable, high in T1 only.
- io_m  output  1  captured req_io, driven T1..T4; 0 in IDLE.
- rd_n  output  1  active-low read strobe.
- wr_n  output  1  active-low write strobe.
- a_hi  output  8  addr[15:8], driven T1..T4; 0 in IDLE.
- ad_out  output  8  multiplexed AD bus drive value.
- ad_oe  output  1  AD bus output enable.
- ad_in  input  8  AD bus sampled value.
- ready  input  1  responder ready; 0 inserts wait states.

Behaviour:
- Reset (async, immediate): state=IDLE; ale=0, rd_n=1, wr_n=1, ad_oe=0, ad_out=0, a_hi=0, io_m=0, done=0, err=0, rdata=0, wait counter=0.
- Reset mid-cycle: strobes deassert at once and no done is produced; the in-flight request is lost.
- State register is one-hot: IDLE, T1, T2, TW, T3, T4. All bus outputs decode from state plus captured registers only, with no combinational path from req* to bus pins.
- IDLE:
  - req_rdy=1.
  - On a clk edge with req=1, capture wr/io/addr/wdata, clear the wait counter, go to T1.
  - Otherwise stay in IDLE.
- T1 (1 cycle): ale=1, ad_oe=1, ad_out=addr[7:0], a_hi=addr[15:8], io_m=io. Go to T2.
- T2 (1 cycle):
  - ale=0.
  - Read: rd_n=0, ad_oe=0.
  - Write: wr_n=0, ad_oe=1, ad_out=wdata.
  - At the edge ending T2: ready=1 goes to T3; ready=0 goes to TW.
- TW:
  - Outputs identical to T2. The wait counter increments each TW edge.
  - ready=1 goes to T3.
  - ready=0 with counter==MAX_WAIT-1 (i.e. the MAX_WAIT-th TW cycle) goes to T4 with timeout flag set.
  - Otherwise stay in TW.
- T3 (1 cycle):
  - Outputs identical to T2.
  - Read: at the edge ending T3, rdata<=ad_in.
  - Go to T4.
- T4 (1 cycle):
  - rd_n=wr_n=1, ad_oe=0, ale=0; a_hi and io_m still driven.
  - done=1; err=timeout flag.
  - rdata is not updated on a timed-out read.
  - Go to IDLE, clearing the timeout flag.
- Latency, zero-wait cycle: acceptance edge, then T1, T2, T3, T4. done rises 4 cycles after acceptance. Each TW adds 1 cycle.
- Back-to-back: a new request is accepted only in IDLE, so there is a minimum 1 IDLE cycle between T4 and the next T1. req is ignored while busy; nothing is queued.
- rd_n and wr_n are never low in the same cycle. Neither strobe is ever low in IDLE, T1 or T4.
- ready is ignored in all states except T2 and TW.

Test Plan:
- Zero-wait memory read, addr=0x12A5, ready=1, ad_in=0x3C during T3:
  - ale=1 with ad_out=0xA5, a_hi=0x12, io_m=0 in T1.
  - rd_n=0 for exactly 2 cycles.
  - done 4 cycles after acceptance with rdata=0x3C, err=0.
- I/O write, addr=0x0040, wdata=0x7E, ready low for 2 cycles after T2:
  - io_m=1; wr_n=0 for 4 cycles; ad_out=0x7E, ad_oe=1 during T2/TW/TW/T3.
  - done at cycle 6 after acceptance, err=0.
- Timeout with MAX_WAIT=8, ready stuck 0, read:
  - exactly 8 TW cycles, then T4 with done=1, err=1.
  - rdata keeps its previous value; rd_n=1 in T4.
- Reset asserted mid-TW of a write:
  - wr_n=1, ad_oe=0, a_hi=0 in the same cycle as rst.
  - no done pulse.
  - after release, req_rdy=1 and a new read completes normally.
- req held high continuously, alternating read/write:
  - acceptances are 5 cycles apart (4-cycle bus cycle + 1 IDLE).
  - req changes while busy do not affect the captured addr/data.
  - rd_n and wr_n are never simultaneously 0.
